glyph_sprite_renderer: RTL and testbench

//  Multi-glyph sprite pixel generator for the display path. Draws one of NUM_GLYPHS

---
 rtl/glyph_sprite_if.sv | 38 +++
 rtl/glyph_sprite_renderer.sv | 146 ++++++++++++++
 tb/tb_glyph_sprite_renderer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/glyph_sprite_if.sv
// +--------------------------------------------------------------------------+
// | glyph_sprite_if                                                          |
// | Per-pixel timing, shadow-register inputs and pixel outputs of the        |
// | glyph sprite renderer.                                                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface glyph_sprite_if #(
  parameter int GLYPH_W = 4
);
  logic               frame_start_in;
  logic [10:0]        hcount_in;
  logic [9:0]         vcount_in;
  logic [10:0]        x_in;
  logic [9:0]         y_in;
  logic [GLYPH_W-1:0] glyph_in;
  logic [1:0]         scale_in;
  logic [11:0]        tint_in;
  logic               enable_in;
  logic               blink_in;
  logic [11:0]        pixel_out;
  logic               hit_out;

  modport master (
    output frame_start_in, hcount_in, vcount_in, x_in, y_in, glyph_in,
           scale_in, tint_in, enable_in, blink_in,
    input  pixel_out, hit_out
  );

  modport slave (
    input  frame_start_in, hcount_in, vcount_in, x_in, y_in, glyph_in,
           scale_in, tint_in, enable_in, blink_in,
    output pixel_out, hit_out
  );
endinterface

`default_nettype wire

// File: rtl/glyph_sprite_renderer.sv
// +--------------------------------------------------------------------------+
// | glyph_sprite_renderer                                                    |
// | Zoomable, tinted, blinking indexed-colour glyph sprite with a fixed      |
// | three-cycle pixel latency.                                               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module glyph_sprite_renderer #(
  parameter int WIDTH      = 16,
  parameter int HEIGHT     = 16,
  parameter int NUM_GLYPHS = 10,
  parameter int MAX_SCALE  = 2,
  parameter int BLINK_LOG2 = 5
) (
  input  wire logic       pixel_clk_in,
  input  wire logic       rst_in,
  glyph_sprite_if.slave   bus
);

  localparam int c_GW         = $clog2(NUM_GLYPHS);
  localparam int c_GLYPH_SIZE = WIDTH * HEIGHT;
  localparam int c_AW         = $clog2(NUM_GLYPHS * WIDTH * HEIGHT);
  localparam int c_CW         = $clog2(WIDTH);
  localparam int c_RW         = $clog2(HEIGHT);

  localparam logic [c_GW:0]       c_NUM_GLYPHS = (c_GW + 1)'(NUM_GLYPHS);
  localparam logic [1:0]          c_MAX_SCALE  = 2'(MAX_SCALE);
  localparam logic [BLINK_LOG2:0] c_CTR_ONE    = (BLINK_LOG2 + 1)'(1);

  // Glyph ROM contents: every fourth column is transparent, the rest are a
  // scrambled pattern of the address so each glyph looks distinct.
  function automatic logic [7:0] f_glyph_rom(input logic [c_AW-1:0] a);
    logic [31:0] t;
    t = 32'(a);
    t = t ^ (t >> 4);
    return (a[1:0] == 2'b00) ? 8'h00 : t[7:0];
  endfunction

  // Colour map entry is {i[3:0]^5, i[7:4]^A}; only the upper nibble is displayed.
  function automatic logic [3:0] f_cmap_shade(input logic [7:0] i);
    return i[3:0] ^ 4'h5;
  endfunction

  logic [10:0]       r_x;
  logic [9:0]        r_y;
  logic [c_GW-1:0]   r_glyph;
  logic [1:0]        r_scale;
  logic [11:0]       r_tint;
  logic              r_enable;
  logic              r_blink;
  logic [BLINK_LOG2:0] r_blink_ctr;

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_x         <= '0;
      r_y         <= '0;
      r_glyph     <= '0;
      r_scale     <= '0;
      r_tint      <= 12'hFFF;
      r_enable    <= 1'b0;
      r_blink     <= 1'b0;
      r_blink_ctr <= '0;
    end else if (bus.frame_start_in) begin
      r_x         <= bus.x_in;
      r_y         <= bus.y_in;
      r_glyph     <= bus.glyph_in;
      r_scale     <= bus.scale_in;
      r_tint      <= bus.tint_in;
      r_enable    <= bus.enable_in;
      r_blink     <= bus.blink_in;
      r_blink_ctr <= r_blink_ctr + c_CTR_ONE;
    end
  end

  logic [1:0]      w_scale;
  logic [11:0]     w_x_end;
  logic [10:0]     w_y_end;
  logic [10:0]     w_dx;
  logic [9:0]      w_dy;
  logic [c_CW-1:0] w_col;
  logic [c_RW-1:0] w_row;
  logic            w_glyph_ok;
  logic            w_hit;
  logic            w_qual;
  logic [c_AW-1:0] w_addr;

  // Extents are one bit wider than the coordinates so a sprite near the
  // right/bottom edge never wraps back to column/row 0.
  always_comb begin
    w_scale    = (r_scale > c_MAX_SCALE) ? c_MAX_SCALE : r_scale;
    w_x_end    = {1'b0, r_x} + (12'(WIDTH) << w_scale);
    w_y_end    = {1'b0, r_y} + (11'(HEIGHT) << w_scale);
    w_dx       = bus.hcount_in - r_x;
    w_dy       = bus.vcount_in - r_y;
    w_col      = c_CW'(w_dx >> w_scale);
    w_row      = c_RW'(w_dy >> w_scale);
    w_glyph_ok = ({1'b0, r_glyph} < c_NUM_GLYPHS);
    w_hit      = ({1'b0, bus.hcount_in} >= {1'b0, r_x}) &&
                 ({1'b0, bus.hcount_in} <  w_x_end) &&
                 ({1'b0, bus.vcount_in} >= {1'b0, r_y}) &&
                 ({1'b0, bus.vcount_in} <  w_y_end);
    w_qual     = w_hit && r_enable && w_glyph_ok &&
                 !(r_blink && r_blink_ctr[BLINK_LOG2]);
    w_addr     = '0;
    if (w_glyph_ok) begin
      w_addr = c_AW'(r_glyph) * c_AW'(c_GLYPH_SIZE) +
               c_AW'(w_row) * c_AW'(WIDTH) + c_AW'(w_col);
    end
  end

  logic        r_q1;
  logic [7:0]  r_index;
  logic [11:0] r_tint1;
  logic        r_opaque;
  logic [3:0]  r_shade;
  logic [11:0] r_tint2;
  logic [11:0] r_pixel;
  logic        r_hit;

  // Tint rides along with the data so a frame_start mid-pipeline cannot
  // recolour pixels already in flight.
  always_ff @(posedge pixel_clk_in) begin
    r_index <= f_glyph_rom(w_addr);
    r_tint1 <= r_tint;
    r_shade <= f_cmap_shade(r_index);
    r_tint2 <= r_tint1;
    if (rst_in) begin
      r_q1     <= 1'b0;
      r_opaque <= 1'b0;
      r_pixel  <= '0;
      r_hit    <= 1'b0;
    end else begin
      r_q1     <= w_qual;
      r_opaque <= r_q1 && (r_index != 8'h00);
      r_pixel  <= r_opaque ? ({r_shade, r_shade, r_shade} & r_tint2) : 12'h000;
      r_hit    <= r_opaque;
    end
  end

  assign bus.pixel_out = r_pixel;
  assign bus.hit_out   = r_hit;

endmodule

`default_nettype wire

// File: tb/tb_glyph_sprite_renderer.sv
// +--------------------------------------------------------------------------+
// | tb_glyph_sprite_renderer                                                 |
// | Directed and randomized checks of the renderer against a pixel model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_glyph_sprite_renderer;

  localparam int BL = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  glyph_sprite_if #(.GLYPH_W(4)) bus ();

  glyph_sprite_renderer #(
    .WIDTH(16), .HEIGHT(16), .NUM_GLYPHS(10), .MAX_SCALE(2), .BLINK_LOG2(BL)
  ) dut (
    .pixel_clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  // Glyph index at source (row,col) of glyph g, derived from the ROM pattern.
  function automatic int m_index(int g, int row, int col);
    int r;
    r = row * 16 + col;
    if (col % 4 == 0) return 0;
    return (r ^ (g * 16 + (r >> 4))) & 255;
  endfunction

  function automatic logic [12:0] model_out(int h, int v, int x, int y, int g,
                                            int sc, int tint, int en, int bl, int ctr);
    int s, w, col, row, idx, m;
    s = (sc > 2) ? 2 : sc;
    w = 16 << s;
    if (en == 0 || g >= 10 || (bl != 0 && ((ctr >> BL) & 1) == 1)) return 13'h0;
    if (h < x || h >= x + w || v < y || v >= y + w) return 13'h0;
    col = (h - x) >> s;
    row = (v - y) >> s;
    idx = m_index(g, row, col);
    if (idx == 0) return 13'h0;
    m = (idx & 15) ^ 5;
    return {1'b1, 12'((m * 12'h111) & tint)};
  endfunction

  // Model shadow state and 3-deep expectation pipe
  int sh_x, sh_y, sh_g, sh_s, sh_t, sh_en, sh_bl, ctr;
  logic [12:0] p0, p1, p2;
  logic armed = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      sh_x = 0; sh_y = 0; sh_g = 0; sh_s = 0; sh_t = 12'hFFF; sh_en = 0; sh_bl = 0;
      ctr = 0; p0 = '0; p1 = '0; p2 = '0; armed = 1'b1;
    end else begin
      p2 = p1; p1 = p0;
      p0 = model_out(int'(bus.hcount_in), int'(bus.vcount_in), sh_x, sh_y, sh_g,
                     sh_s, sh_t, sh_en, sh_bl, ctr);
      if (bus.frame_start_in) begin
        sh_x = int'(bus.x_in); sh_y = int'(bus.y_in); sh_g = int'(bus.glyph_in);
        sh_s = int'(bus.scale_in); sh_t = int'(bus.tint_in);
        sh_en = int'(bus.enable_in); sh_bl = int'(bus.blink_in);
        ctr = (ctr + 1) % (2 << BL);
      end
    end
    #1;
    if (armed) begin
      total++;
      if ({bus.hit_out, bus.pixel_out} !== p2) begin
        bad++;
        $display("FAIL model t=%0t: got hit=%b pixel=%h, want hit=%b pixel=%h",
                 $time, bus.hit_out, bus.pixel_out, p2[12], p2[11:0]);
      end
    end
  end

  task automatic set_frame(input int x, y, g, s, t, en, bl);
    @(negedge clk);
    bus.x_in = 11'(x); bus.y_in = 10'(y); bus.glyph_in = 4'(g);
    bus.scale_in = 2'(s); bus.tint_in = 12'(t); bus.enable_in = 1'(en);
    bus.blink_in = 1'(bl); bus.frame_start_in = 1'b1;
    @(negedge clk);
    bus.frame_start_in = 1'b0;
  endtask

  task automatic probe(input int h, v, input logic [11:0] epix, input string name);
    @(negedge clk);
    bus.hcount_in = 11'(h); bus.vcount_in = 10'(v);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (bus.pixel_out !== epix || bus.hit_out !== (epix != 12'h000)) begin
      bad++;
      $display("FAIL %s: got pixel=%h hit=%b, want pixel=%h hit=%b",
               name, bus.pixel_out, bus.hit_out, epix, (epix != 12'h000));
    end
  endtask

  task automatic pin(input logic [12:0] got, input logic [12:0] want, input string name);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  logic [11:0] blink_exp [6];

  initial begin
    bus.frame_start_in = 0; bus.hcount_in = 0; bus.vcount_in = 0;
    bus.x_in = 0; bus.y_in = 0; bus.glyph_in = 0; bus.scale_in = 0;
    bus.tint_in = 0; bus.enable_in = 0; bus.blink_in = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    pin(model_out(101, 50, 100, 50, 7, 0, 12'hFFF, 1, 0, 0), 13'h1444, "model_g7_col1");
    pin(13'(m_index(7, 0, 15)), 13'h07F, "model_index_g7_c15");
    pin(model_out(163, 50, 100, 50, 7, 2, 12'hF00, 1, 0, 0), 13'h1A00, "model_tint");

    probe(101, 50, 12'h000, "reset_disabled");

    set_frame(100, 50, 7, 0, 12'hFFF, 1, 0);
    probe(99,  50, 12'h000, "left_of_sprite");
    probe(100, 50, 12'h000, "transparent_col0");
    probe(101, 50, 12'h444, "g7_col1");
    probe(102, 50, 12'h777, "g7_col2");
    probe(116, 50, 12'h000, "right_of_sprite");

    set_frame(100, 50, 7, 3, 12'hFFF, 1, 0);
    probe(107, 53, 12'h444, "scale3_zoom_col1");
    probe(163, 50, 12'hAAA, "scale3_last_col");
    probe(164, 50, 12'h000, "scale3_extent_end");

    set_frame(100, 50, 7, 2, 12'hF00, 1, 0);
    probe(163, 50, 12'hA00, "tint_f00");

    set_frame(100, 50, 7, 0, 12'hFFF, 1, 0);
    @(negedge clk); bus.x_in = 11'd200;
    probe(101, 50, 12'h444, "midframe_old_pos");
    probe(201, 50, 12'h000, "midframe_new_pos_dark");
    set_frame(200, 50, 7, 0, 12'hFFF, 1, 0);
    probe(201, 50, 12'h444, "next_frame_new_pos");

    set_frame(100, 50, 12, 0, 12'hFFF, 1, 0);
    probe(101, 50, 12'h000, "glyph12_hidden");

    set_frame(2040, 50, 7, 2, 12'hFFF, 1, 0);
    probe(2047, 50, 12'h444, "edge_col_drawn");
    probe(2039, 50, 12'h000, "edge_left_dark");
    probe(5,    50, 12'h000, "edge_no_wrap");

    set_frame(100, 50, 7, 0, 12'hFFF, 1, 0);
    probe(101, 50, 12'h444, "pre_reset_visible");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #2;
    pin({bus.hit_out, bus.pixel_out}, 13'h0000, "reset_next_cycle");
    @(negedge clk); rst = 1'b0;
    probe(101, 50, 12'h000, "post_reset_dark");

    blink_exp = '{12'h444, 12'h000, 12'h000, 12'h444, 12'h444, 12'h000};
    for (int k = 0; k < 6; k++) begin
      set_frame(100, 50, 7, 0, 12'hFFF, 1, 1);
      probe(101, 50, blink_exp[k], $sformatf("blink_frame%0d", k + 1));
    end

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 399) == 0);
      bus.frame_start_in = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: bus.x_in = 11'($urandom_range(0, 2047));
        1: bus.x_in = 11'd100;
        2: bus.x_in = 11'd2040;
        default: bus.x_in = 11'd1990;
      endcase
      bus.y_in      = ($urandom_range(0, 1) == 0) ? 10'd50 : 10'($urandom_range(0, 1023));
      bus.glyph_in  = 4'($urandom_range(0, 15));
      bus.scale_in  = 2'($urandom_range(0, 3));
      bus.tint_in   = 12'($urandom);
      bus.enable_in = ($urandom_range(0, 7) != 0);
      bus.blink_in  = ($urandom_range(0, 2) == 0);
      bus.hcount_in = 11'(sh_x + int'($urandom_range(0, 90)) - 10);
      bus.vcount_in = 10'(sh_y + int'($urandom_range(0, 80)) - 6);
    end
    rst = 1'b0;
    bus.frame_start_in = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
